// File: rtl/pseudo_linear_learner.sv
// Binary pseudo-linear classifier: counts p&data and p in CHUNK-bit slices,
// decides, and on a training error flips parameter bits slice by slice.
module pseudo_linear_learner #(
    parameter int N_IN  = 784,
    parameter int CHUNK = 16,
    parameter int THR_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N_IN-1:0]    in_data,
    input  logic               in_label,
    input  logic               in_train,
    input  logic [THR_W-1:0]   threshold,
    input  logic               clear_p,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               result,
    output logic               error,
    output logic [N_IN-1:0]    pm,
    output logic [15:0]        err_cnt
);

    localparam int CNT_W  = $clog2(N_IN + 1);
    localparam int BASE_W = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam logic [BASE_W-1:0] LAST_BASE = BASE_W'(N_IN - CHUNK);
    localparam logic [BASE_W-1:0] STEP      = BASE_W'(CHUNK);
    localparam logic [CNT_W-1:0]  ONE       = CNT_W'(1);

    typedef enum logic [2:0] {IDLE, COUNT, DECIDE, UPDATE, DONE} state_t;

    state_t             state_reg;
    logic [N_IN-1:0]    p_reg;
    logic [N_IN-1:0]    data_reg;
    logic               label_reg;
    logic               train_reg;
    logic [THR_W-1:0]   thr_reg;
    logic [BASE_W-1:0]  base_reg;
    logic [CNT_W-1:0]   num_reg;
    logic [CNT_W-1:0]   num_p_reg;
    logic               result_reg;
    logic               error_reg;
    logic               out_valid_reg;
    logic [15:0]        err_cnt_reg;

    logic [CHUNK-1:0]   p_chunk;
    logic [CHUNK-1:0]   d_chunk;
    logic [CHUNK-1:0]   flip;
    logic [CNT_W-1:0]   chunk_and_cnt;
    logic [CNT_W-1:0]   chunk_p_cnt;
    logic               decide_result;
    logic               decide_error;

    function automatic logic fwd(input logic [CNT_W-1:0] a,
                                 input logic [CNT_W-1:0] b,
                                 input logic [THR_W-1:0] t);
        return ((b >> t) >= a) ? 1'b0 : 1'b1;
    endfunction

    assign p_chunk = p_reg[base_reg +: CHUNK];
    assign d_chunk = data_reg[base_reg +: CHUNK];

    always_comb begin
        chunk_and_cnt = '0;
        chunk_p_cnt   = '0;
        for (int i = 0; i < CHUNK; i++) begin
            chunk_and_cnt = chunk_and_cnt + CNT_W'(p_chunk[i] & d_chunk[i]);
            chunk_p_cnt   = chunk_p_cnt + CNT_W'(p_chunk[i]);
        end
    end

    assign decide_result = fwd(num_reg, num_p_reg, thr_reg);
    assign decide_error  = decide_result ^ label_reg;

    // Each bit's flip uses the frozen pre-update counts and result, so the
    // order in which slices are rewritten does not matter.
    genvar gi;
    generate
        for (gi = 0; gi < CHUNK; gi++) begin : g_flip
            logic [CNT_W-1:0] num_r;
            logic [CNT_W-1:0] num_p_r;
            always_comb begin
                num_r = num_reg;
                if (d_chunk[gi] && p_chunk[gi])
                    num_r = num_reg - ONE;
                else if (d_chunk[gi])
                    num_r = num_reg + ONE;
                num_p_r = p_chunk[gi] ? (num_p_reg - ONE) : (num_p_reg + ONE);
            end
            assign flip[gi] = (fwd(num_r, num_p_r, thr_reg) != result_reg);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            p_reg         <= '0;
            data_reg      <= '0;
            label_reg     <= 1'b0;
            train_reg     <= 1'b0;
            thr_reg       <= '0;
            base_reg      <= '0;
            num_reg       <= '0;
            num_p_reg     <= '0;
            result_reg    <= 1'b0;
            error_reg     <= 1'b0;
            out_valid_reg <= 1'b0;
            err_cnt_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (clear_p) begin
                        p_reg       <= '0;
                        err_cnt_reg <= '0;
                    end
                    if (in_valid) begin
                        data_reg  <= in_data;
                        label_reg <= in_label;
                        train_reg <= in_train;
                        thr_reg   <= threshold;
                        base_reg  <= '0;
                        num_reg   <= '0;
                        num_p_reg <= '0;
                        state_reg <= COUNT;
                    end
                end
                COUNT: begin
                    num_reg   <= num_reg + chunk_and_cnt;
                    num_p_reg <= num_p_reg + chunk_p_cnt;
                    if (base_reg == LAST_BASE) begin
                        base_reg  <= '0;
                        state_reg <= DECIDE;
                    end else begin
                        base_reg <= base_reg + STEP;
                    end
                end
                DECIDE: begin
                    result_reg <= decide_result;
                    error_reg  <= decide_error;
                    if (decide_error && (err_cnt_reg != 16'hFFFF))
                        err_cnt_reg <= err_cnt_reg + 16'd1;
                    if (train_reg && decide_error) begin
                        state_reg <= UPDATE;
                    end else begin
                        out_valid_reg <= 1'b1;
                        state_reg     <= DONE;
                    end
                end
                UPDATE: begin
                    p_reg[base_reg +: CHUNK] <= p_chunk ^ flip;
                    if (base_reg == LAST_BASE) begin
                        base_reg      <= '0;
                        out_valid_reg <= 1'b1;
                        state_reg     <= DONE;
                    end else begin
                        base_reg <= base_reg + STEP;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = out_valid_reg;
    assign result    = result_reg;
    assign error     = error_reg;
    assign pm        = p_reg;
    assign err_cnt   = err_cnt_reg;

endmodule

// File: tb/tb_pseudo_linear_learner.sv
// Self-checking bench: directed scenarios plus random samples against a
// whole-vector reference model of the learner.
module tb_pseudo_linear_learner;

    localparam int N  = 16;
    localparam int CH = 4;
    localparam int TW = 4;
    localparam int NC = N / CH;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [N-1:0]  in_data = '0;
    logic          in_label = 1'b0;
    logic          in_train = 1'b0;
    logic [TW-1:0] threshold = '0;
    logic          clear_p = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          result;
    logic          error;
    logic [N-1:0]  pm;
    logic [15:0]   err_cnt;

    int checks   = 0;
    int failures = 0;
    int txn      = 0;

    logic [N-1:0] m_p   = '0;
    logic [15:0]  m_err = '0;

    pseudo_linear_learner #(.N_IN(N), .CHUNK(CH), .THR_W(TW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_label(in_label), .in_train(in_train),
        .threshold(threshold), .clear_p(clear_p),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .error(error), .pm(pm), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit fwd_m(input int a, input int b, input int t);
        return ((b >> t) >= a) ? 1'b0 : 1'b1;
    endfunction

    // clr_mode: 0 none, 1 clear_p with the handshake, 2 clear_p during COUNT
    task automatic do_sample(input logic [N-1:0] d, input bit lbl, input bit trn,
                             input int thr, input int clr_mode, input int hold);
        int num, np, nr, npr, lat, cyc;
        bit res, er;
        logic [N-1:0] new_p;
        if (clr_mode == 1) begin
            m_p   = '0;
            m_err = '0;
        end
        num   = $countones(m_p & d);
        np    = $countones(m_p);
        res   = fwd_m(num, np, thr);
        er    = res ^ lbl;
        if (er && m_err != 16'hFFFF) m_err = m_err + 16'd1;
        new_p = m_p;
        if (trn && er) begin
            for (int k = 0; k < N; k++) begin
                nr = num;
                if (d[k] && m_p[k]) nr = num - 1;
                else if (d[k])      nr = num + 1;
                npr = m_p[k] ? np - 1 : np + 1;
                if (fwd_m(nr, npr, thr) != res) new_p[k] = ~m_p[k];
            end
        end
        lat = (trn && er) ? 2 * NC + 2 : NC + 2;

        check_eq("in_ready_idle", in_ready, 1);
        in_data   = d;
        in_label  = lbl;
        in_train  = trn;
        threshold = TW'(thr);
        clear_p   = (clr_mode == 1);
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        clear_p  = 1'b0;
        cyc = 1;
        if (clr_mode == 2) begin
            clear_p = 1'b1;
            @(posedge clk); #1;
            clear_p = 1'b0;
            cyc = 2;
        end
        while (!out_valid && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        check_eq("latency", cyc, lat);
        check_eq("result", result, res);
        check_eq("error", error, er);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check_eq("hold_valid", out_valid, 1);
            check_eq("hold_result", result, res);
            check_eq("hold_error", error, er);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        m_p = new_p;
        check_eq("pm", pm, m_p);
        check_eq("err_cnt", err_cnt, m_err);
        check_eq("valid_drop", out_valid, 0);
        check_eq("ready_back", in_ready, 1);
        txn++;
        $display("txn %0d data=%04h label=%0d train=%0d thr=%0d res=%0d err=%0d lat=%0d pm=%04h err_cnt=%0d",
                 txn, d, lbl, trn, thr, result, error, cyc, pm, err_cnt);
    endtask

    initial begin
        int r;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_pm", pm, 0);
        check_eq("rst_err_cnt", err_cnt, 0);
        check_eq("rst_result", result, 0);
        check_eq("rst_error", error, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Learn from all-ones, then recall, then zero data, then infer with error
        do_sample(16'hFFFF, 1'b1, 1'b1, 1, 0, 3);
        do_sample(16'hFFFF, 1'b1, 1'b1, 1, 0, 0);
        do_sample(16'h0000, 1'b1, 1'b1, 1, 0, 0);
        do_sample(16'h0000, 1'b1, 1'b0, 1, 0, 0);

        // clear_p ignored while counting, honoured in IDLE
        do_sample(16'h5A5A, 1'b0, 1'b0, 1, 2, 0);
        clear_p = 1'b1;
        @(posedge clk); #1;
        clear_p = 1'b0;
        m_p   = '0;
        m_err = '0;
        check_eq("clear_pm", pm, 0);
        check_eq("clear_err_cnt", err_cnt, 0);

        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 9);
            do_sample(16'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0),
                      $urandom_range(0, 3), (r == 0) ? 1 : 0, $urandom_range(0, 2));
        end

        // Reset during UPDATE: error is guaranteed with p cleared and label=1
        in_data   = 16'hFFFF;
        in_label  = 1'b1;
        in_train  = 1'b1;
        threshold = 4'd1;
        clear_p   = 1'b1;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        clear_p  = 1'b0;
        repeat (NC + 3) @(posedge clk);
        #1;
        check_eq("pre_rst_valid", out_valid, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_p   = '0;
        m_err = '0;
        check_eq("mid_rst_pm", pm, 0);
        check_eq("mid_rst_valid", out_valid, 0);
        check_eq("mid_rst_ready", in_ready, 1);
        check_eq("mid_rst_err_cnt", err_cnt, 0);
        do_sample(16'h0F0F, 1'b1, 1'b1, 0, 0, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pseudo_linear_learner.md
PSEUDO_LINEAR_LEARNER -- requirements
Module: pseudo_linear_learner

Interface
REQ-001 SHALL have parameter N_IN, default 784, meaning number of binary input features and parameter bits.
REQ-002 SHALL have parameter CHUNK, default 16, meaning feature bits processed per cycle; N_IN % CHUNK == 0 is required.
REQ-003 SHALL have parameter THR_W, default 4, meaning threshold width.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 SHALL have port clk, input, 1 bit, the sole clock (rising edge).
REQ-006 SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-007 SHALL have port in_valid, input, 1 bit, sample offered.
REQ-008 SHALL have port in_ready, output, 1 bit, block accepts a sample.
REQ-009 SHALL have port in_data, input, N_IN bits, binary feature vector.
REQ-010 SHALL have port in_label, input, 1 bit, target class bit.
REQ-011 SHALL have port in_train, input, 1 bit: 1 = train, 0 = infer-only.
REQ-012 SHALL have port threshold, input, THR_W bits, shift amount, sampled at handshake.
REQ-013 SHALL have port clear_p, input, 1 bit, zeroes parameters.
REQ-014 SHALL have port out_valid, output, 1 bit, result available.
REQ-015 SHALL have port out_ready, input, 1 bit, result consumed.
REQ-016 SHALL have port result, output, 1 bit, forward prediction.
REQ-017 SHALL have port error, output, 1 bit, result XOR label.
REQ-018 SHALL have port pm, output, N_IN bits, current parameter vector p.
REQ-019 SHALL have port err_cnt, output, 16 bits, count of erroneous predictions.

Function
REQ-020 SHALL implement FSM states IDLE, COUNT, DECIDE, UPDATE, DONE.
REQ-021 SHALL assert in_ready only in IDLE; in_valid&in_ready captures in_data, in_label, in_train, threshold and moves to COUNT.
REQ-022 SHALL in COUNT accumulate, CHUNK bits per cycle, num = popcount(p & data) and num_p = popcount(p), each CNT_W = clog2(N_IN+1) bits; COUNT lasts N_IN/CHUNK cycles.
REQ-023 SHALL define forward(a,b) = 0 if (b >> thr) >= a, else 1; DECIDE registers result = forward(num,num_p) and error = result ^ label.
REQ-024 SHALL go DECIDE->UPDATE if train & error, else DECIDE->DONE.
REQ-025 SHALL in UPDATE, per bit k (CHUNK per cycle, N_IN/CHUNK cycles), derive num_r = num-1 if data[k]&p[k], num+1 if data[k]&!p[k], else num; num_p_r = num_p-1 if p[k], else num_p+1; flip p[k] iff forward(num_r,num_p_r) != result.
REQ-026 SHALL compute all UPDATE flips from the pre-update num, num_p and result (batch semantics); no arithmetic under/overflow is possible and none is required to be handled.
REQ-027 SHALL increment err_cnt in DECIDE when error=1 in either mode, saturating at 16'hFFFF.
REQ-028 SHALL hold out_valid, result and error stable in DONE until out_ready; DONE & out_ready -> IDLE.
REQ-029 SHALL clear p and err_cnt on clear_p only in IDLE; clear_p in other states is ignored; clear_p together with a handshake clears first, then the sample sees p=0.
REQ-030 SHALL give latency from handshake to out_valid of N_IN/CHUNK+2 cycles without update and 2*N_IN/CHUNK+2 cycles with update.

Reset
REQ-031 SHALL on rst set state IDLE, p=0, counters 0, err_cnt=0, out_valid=0, result=0, error=0, in_ready=1 the next cycle; rst mid-operation aborts without partial p update being kept.

Verification (N_IN=16, CHUNK=4, threshold=1)
REQ-032 SHALL cover: reset, then train data=16'hFFFF, label=1 -> result=0, error=1, out_valid 10 cycles after handshake, pm=16'hFFFF, err_cnt=1.
REQ-033 SHALL cover: repeat the same sample -> num=16, num_p=16, result=1, error=0, out_valid after 6 cycles, pm unchanged, err_cnt=1.
REQ-034 SHALL cover: with p=16'hFFFF, train data=16'h0000, label=1 -> result=0, error=1, no flips, pm=16'hFFFF, err_cnt increments.
REQ-035 SHALL cover: infer-mode sample producing error -> err_cnt increments, pm unchanged, UPDATE never entered.
REQ-036 SHALL cover: clear_p pulsed during COUNT -> ignored; pulsed in IDLE -> pm=0, err_cnt=0.
REQ-037 SHALL cover: rst asserted mid-UPDATE -> pm=0, out_valid=0, in_ready=1 next cycle; out_ready held low in DONE keeps outputs stable.
